// File: rtl/host_mist_console_fifo.sv
// Byte FIFO behind the console UART receiver: one write per rising edge of the receiver strobe, one pop per rd_req.
// Optional macro CONSOLE_LINE_EN adds a count of buffered 0x0A bytes and the line_ready output.
module host_mist_console_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_strobe,
  input  logic                  rd_req,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr
`ifdef CONSOLE_LINE_EN
  ,
  output logic                  line_ready
`endif
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = 0;
  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

  // Handshake: rd_req is a request with no ready back; a pop is taken only when
  // empty=0 in that cycle, and its byte appears on rd_data with a one-cycle
  // rd_valid pulse on the following cycle. rd_req while empty is silently dropped.

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  strobe_d;
  logic                  wr_ev;
  logic                  rd_ev;
  logic                  wr_acc;
  logic                  wr_drop;
  logic [7:0]            rd_byte;
  logic [DEPTH_LOG2:0]   count_next;

  assign wr_ev   = in_strobe & ~strobe_d;
  assign rd_ev   = rd_req & ~empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_acc  = wr_ev & (~full | rd_ev);
  assign wr_drop = wr_ev & full & ~rd_ev;
  assign rd_byte = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_ev) begin
      count_next = count + CNT_ONE;
    end else if (rd_ev && !wr_acc) begin
      count_next = count - CNT_ONE;
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers are zeroed.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_d <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      strobe_d <= in_strobe;
      rd_valid <= rd_ev;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ev) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= rd_byte;
      end
      count <= count_next;
      empty <= (count_next == CNT_ZERO);
      full  <= (count_next == CNT_DEPTH);
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (wr_drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef CONSOLE_LINE_EN
  logic [DEPTH_LOG2:0] lines;
  logic [DEPTH_LOG2:0] lines_next;
  logic                wr_nl;
  logic                rd_nl;

  assign wr_nl = wr_acc & (in_data == 8'h0A);
  assign rd_nl = rd_ev & (rd_byte == 8'h0A);

  always_comb begin
    lines_next = lines;
    if (wr_nl && !rd_nl) begin
      lines_next = lines + CNT_ONE;
    end else if (rd_nl && !wr_nl) begin
      lines_next = lines - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lines      <= '0;
      line_ready <= 1'b0;
    end else begin
      lines      <= lines_next;
      line_ready <= (lines_next != CNT_ZERO);
    end
  end
`endif

endmodule

// File: tb/tb_host_mist_console_fifo.sv
// Self-checking bench for host_mist_console_fifo: directed scenarios plus random traffic against a queue model.
module tb_host_mist_console_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_strobe;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;
  logic          ovf_clr;
`ifdef CONSOLE_LINE_EN
  logic          line_ready;
`endif

  host_mist_console_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef CONSOLE_LINE_EN
    , .line_ready(line_ready)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: a byte queue plus the few registered outputs
  logic [7:0] exp_q[$];
  logic       m_strobe_d;
  logic       m_ovf;
  logic [7:0] m_rd_data;
  logic       m_rd_valid;

  function automatic int m_lines();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i] == 8'h0A) n++;
    return n;
  endfunction

  // driver: apply inputs for one cycle, advance the model, sample #1 after the edge
  task automatic step(input logic rst, input logic stb, input logic [7:0] d,
                      input logic req, input logic clr);
    logic rise, pop;
    reset = rst; in_strobe = stb; in_data = d; rd_req = req; ovf_clr = clr;
    if (rst) begin
      exp_q.delete();
      m_strobe_d = 1'b1; m_ovf = 1'b0; m_rd_data = 8'h00; m_rd_valid = 1'b0;
    end else begin
      rise = stb && !m_strobe_d;
      pop  = req && (exp_q.size() > 0);
      m_rd_valid = pop;
      if (pop) m_rd_data = exp_q.pop_front();
      if (rise) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else if (!clr) m_ovf = 1'b1;
      end
      if (clr) m_ovf = 1'b0;
      m_strobe_d = stb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] d, input int hold);
    for (int i = 0; i < hold; i++) step(1'b0, 1'b1, d, 1'b0, 1'b0);
    step(1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    tests_run++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b0 || count !== '0 || empty !== 1'b1 ||
        full !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: rd_data=%h rd_valid=%b count=%0d empty=%b full=%b ovf=%b, required 00 0 0 1 0 0",
               rd_data, rd_valid, count, empty, full, overflow);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    tests_run++;
    if (empty !== 1'b1 || count !== '0) begin
      tests_failed++;
      $display("FAIL reset_strobe_held: empty=%b count=%0d, required 1 0", empty, count);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
    tests_run++;
    if (empty !== 1'b0 || count !== 5'd1) begin
      tests_failed++;
      $display("FAIL reset_new_edge: empty=%b count=%0d, required 0 1", empty, count);
    end
    do_reset();
  endtask

  task automatic test_basic();
    write_byte(8'h41, 20);
    write_byte(8'h42, 20);
    write_byte(8'h43, 20);
    tests_run++;
    if (count !== 5'd3) begin
      tests_failed++;
      $display("FAIL basic_count: count=%0d, required 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== m_rd_data || m_rd_data !== 8'(8'h41 + i)) begin
        tests_failed++;
        $display("FAIL basic_read%0d: rd_valid=%b rd_data=%h, required 1 %h", i, rd_valid, rd_data, 8'(8'h41 + i));
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      tests_run++;
      if (rd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_valid_pulse%0d: rd_valid=%b, required 0", i, rd_valid);
      end
    end
    tests_run++;
    if (empty !== 1'b1 || count !== '0) begin
      tests_failed++;
      $display("FAIL basic_empty_after: empty=%b count=%0d, required 1 0", empty, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) write_byte(8'(i), 2);
    tests_run++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_state: full=%b count=%0d ovf=%b, required 1 16 1", full, count, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        tests_failed++;
        $display("FAIL ovf_read%0d: rd_valid=%b rd_data=%h, required 1 %h", i, rd_valid, rd_data, 8'(i));
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tests_run++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_clear: ovf=%b empty=%b, required 0 1", overflow, empty);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h80 + i), 1);
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h80 || count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_rw: valid=%b data=%h count=%0d ovf=%b full=%b, required 1 80 16 0 1",
               rd_valid, rd_data, count, overflow, full);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
        tests_failed++;
        $display("FAIL full_rw_drain%0d: valid=%b data=%h, required 1 %h", i, rd_valid, rd_data, m_rd_data);
      end
    end
    tests_run++;
    if (rd_data !== 8'hAA || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_rw_last: data=%h empty=%b, required AA 1", rd_data, empty);
    end
    // ovf_clr wins over a drop in the same cycle
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    tests_run++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL ovf_clr_priority: ovf=%b count=%0d, required 0 16", overflow, count);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();
  endtask

  task automatic test_empty();
    logic [7:0] held;
    write_byte(8'h5A, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    held = rd_data;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h5A || held !== 8'h5A) begin
      tests_failed++;
      $display("FAIL empty_read: valid=%b data=%h, required 0 5A", rd_valid, rd_data);
    end
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    tests_run++;
    if (rd_valid !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_wr_rd: valid=%b count=%0d empty=%b, required 0 1 0", rd_valid, count, empty);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin
      tests_failed++;
      $display("FAIL empty_wr_rd_pop: valid=%b data=%h, required 1 77", rd_valid, rd_data);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      write_byte(d, 1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== d) begin
        tests_failed++;
        $display("FAIL wrap%0d: valid=%b data=%h, required 1 %h", i, rd_valid, rd_data, d);
      end
    end
  endtask

  task automatic test_random();
    logic stb;
    int   bad = 0;
    stb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) stb = ~stb;
      step(1'b0, stb, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 40) == 0));
      tests_run++;
      if (rd_valid !== m_rd_valid || rd_data !== m_rd_data || count !== (DL+1)'(exp_q.size()) ||
          empty !== (exp_q.size() == 0) || full !== (exp_q.size() == DEPTH) || overflow !== m_ovf) begin
        tests_failed++;
        if (bad++ < 5)
          $display("FAIL random%0d: valid=%b data=%h count=%0d ovf=%b, required %b %h %0d %b",
                   i, rd_valid, rd_data, count, overflow, m_rd_valid, m_rd_data, exp_q.size(), m_ovf);
      end
    end
    do_reset();
  endtask

`ifdef CONSOLE_LINE_EN
  task automatic test_lines();
    logic [7:0] s [6];
    s[0] = 8'h61; s[1] = 8'h62; s[2] = 8'h0A; s[3] = 8'h63; s[4] = 8'h64; s[5] = 8'h0A;
    foreach (s[i]) write_byte(s[i], 1);
    tests_run++;
    if (line_ready !== 1'b1 || m_lines() != 2) begin
      tests_failed++;
      $display("FAIL lines_two: line_ready=%b, required 1", line_ready);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (line_ready !== 1'b1 || m_lines() != 1) begin
      tests_failed++;
      $display("FAIL lines_one: line_ready=%b, required 1", line_ready);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (line_ready !== 1'b0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL lines_zero: line_ready=%b empty=%b, required 0 1", line_ready, empty);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; in_strobe = 1'b0; in_data = 8'h00; rd_req = 1'b0; ovf_clr = 1'b0;
    m_strobe_d = 1'b1; m_ovf = 1'b0; m_rd_data = 8'h00; m_rd_valid = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_empty();
    test_wrap();
    test_random();
`ifdef CONSOLE_LINE_EN
    test_lines();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
